// File: rtl/rob_pkg.sv
// Shared encodings for the multi-channel reorder buffer: op types, FSM states, null tag.
package rob_pkg;

    localparam logic [2:0] ROB_T_ALU = 3'd0;
    localparam logic [2:0] ROB_T_BR  = 3'd1;
    localparam logic [2:0] ROB_T_LD  = 3'd2;
    localparam logic [2:0] ROB_T_ST  = 3'd3;
    localparam logic [2:0] ROB_T_JAL = 3'd4;

    localparam int unsigned ROB_TAG_NULL = 0;

    typedef enum logic {
        StRun,
        StWait
    } rob_state_e;

endpackage

// File: rtl/reorder_buffer_mc_if.sv
// Issue, writeback, query, commit and rollback bundle of reorder_buffer_mc.
// slave = the ROB, master = the surrounding pipeline.
interface reorder_buffer_mc_if #(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned CDB_N = 3,
    parameter int unsigned XLEN  = 32
);
    logic                     issue_valid_in;
    logic [XLEN-1:0]          issue_pc_in;
    logic [4:0]               issue_rd_in;
    logic [2:0]               issue_type_in;
    logic                     issue_ready_out;
    logic [IDX_W-1:0]         issue_tag_out;
    logic [CDB_N-1:0]         wb_valid_in;
    logic [CDB_N*IDX_W-1:0]   wb_tag_in;
    logic [CDB_N*XLEN-1:0]    wb_data_in;
    logic [CDB_N*XLEN-1:0]    wb_npc_in;
    logic [CDB_N-1:0]         wb_mispred_in;
    logic [IDX_W-1:0]         qa_tag_in;
    logic [IDX_W-1:0]         qb_tag_in;
    logic                     qa_ready_out;
    logic                     qb_ready_out;
    logic [XLEN-1:0]          qa_data_out;
    logic [XLEN-1:0]          qb_data_out;
    logic                     commit_valid_out;
    logic [IDX_W-1:0]         commit_tag_out;
    logic [4:0]               commit_rd_out;
    logic [2:0]               commit_type_out;
    logic [XLEN-1:0]          commit_data_out;
    logic [XLEN-1:0]          commit_pc_out;
    logic                     store_commit_out;
    logic                     store_done_in;
    logic                     rollback_out;
    logic [XLEN-1:0]          rollback_pc_out;
    logic [IDX_W:0]           count_out;

    modport slave (
        input  issue_valid_in, issue_pc_in, issue_rd_in, issue_type_in,
        input  wb_valid_in, wb_tag_in, wb_data_in, wb_npc_in, wb_mispred_in,
        input  qa_tag_in, qb_tag_in, store_done_in,
        output issue_ready_out, issue_tag_out, qa_ready_out, qb_ready_out,
        output qa_data_out, qb_data_out, commit_valid_out, commit_tag_out,
        output commit_rd_out, commit_type_out, commit_data_out, commit_pc_out,
        output store_commit_out, rollback_out, rollback_pc_out, count_out
    );

    modport master (
        output issue_valid_in, issue_pc_in, issue_rd_in, issue_type_in,
        output wb_valid_in, wb_tag_in, wb_data_in, wb_npc_in, wb_mispred_in,
        output qa_tag_in, qb_tag_in, store_done_in,
        input  issue_ready_out, issue_tag_out, qa_ready_out, qb_ready_out,
        input  qa_data_out, qb_data_out, commit_valid_out, commit_tag_out,
        input  commit_rd_out, commit_type_out, commit_data_out, commit_pc_out,
        input  store_commit_out, rollback_out, rollback_pc_out, count_out
    );
endinterface

// File: rtl/rob_wb_match.sv
// CDB tag comparator: reports whether any strobed channel carries tag, and which one
// (highest channel index wins).
module rob_wb_match
    import rob_pkg::*;
#(
    parameter int unsigned IDX_W = 5,
    parameter int unsigned CDB_N = 3,
    parameter int unsigned SelW  = 2
) (
    input  logic [IDX_W-1:0]       tag,
    input  logic [CDB_N-1:0]       wb_valid,
    input  logic [CDB_N*IDX_W-1:0] wb_tag,
    output logic                   hit,
    output logic [SelW-1:0]        sel
);
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int c = 0; c < CDB_N; c++) begin
            if (wb_valid[c] && (wb_tag[c*IDX_W +: IDX_W] == tag)) begin
                hit = 1'b1;
                sel = SelW'(c);
            end
        end
    end
endmodule

// File: rtl/reorder_buffer_mc.sv
// In-order retirement buffer with CDB_N writeback channels, operand queries and
// commit-time rollback. Define ROB_WB_BYPASS_EN to let queries see same-cycle writebacks.
module reorder_buffer_mc
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned IDX_W = 5,
    parameter int unsigned CDB_N = 3,
    parameter int unsigned XLEN  = 32
) (
    input logic                clk_in,
    input logic                rst_n_in,
    input logic                rdy_in,
    reorder_buffer_mc_if.slave bus
);
    localparam int unsigned    SelW    = (CDB_N > 1) ? $clog2(CDB_N) : 1;
    localparam logic [IDX_W:0] CntFull = (IDX_W + 1)'(DEPTH);
    localparam logic [IDX_W:0] CntOne  = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0] IdxOne = IDX_W'(1);

    logic [DEPTH-1:0] valid_q, done_q, mispred_q;
    logic [XLEN-1:0]  pc_q [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  npc_q [DEPTH];
    logic [4:0]       rd_q [DEPTH];
    logic [2:0]       type_q [DEPTH];

    logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]   count_q, count_d;
    rob_state_e       state_q, state_d;

    logic             commit_valid_q, store_commit_q, rollback_q;
    logic [IDX_W-1:0] commit_tag_q;
    logic [4:0]       commit_rd_q;
    logic [2:0]       commit_type_q;
    logic [XLEN-1:0]  commit_data_q, commit_pc_q, rollback_pc_q;

    logic             head_fire, head_store, head_mis, retire, alloc, rollback, issue_ready;
    logic [DEPTH-1:0] wb_hit;
    logic [SelW-1:0]  wb_sel [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        rob_wb_match #(.IDX_W(IDX_W), .CDB_N(CDB_N), .SelW(SelW)) u_match (
            .tag      (IDX_W'(i)),
            .wb_valid (bus.wb_valid_in),
            .wb_tag   (bus.wb_tag_in),
            .hit      (wb_hit[i]),
            .sel      (wb_sel[i])
        );
    end

    assign issue_ready = (count_q < CntFull);

    always_comb begin
        head_fire  = (state_q == StRun) && valid_q[head_q] && done_q[head_q];
        head_store = (type_q[head_q] == ROB_T_ST);
        head_mis   = mispred_q[head_q];
        rollback   = head_fire && head_mis;
        state_d    = state_q;
        retire     = 1'b0;
        unique case (state_q)
            StRun:  if (head_fire && !head_mis) begin
                        if (head_store) state_d = StWait;
                        else            retire  = 1'b1;
                    end
            StWait: if (bus.store_done_in) begin
                        retire  = 1'b1;
                        state_d = StRun;
                    end
            default: state_d = StRun;
        endcase
        // A rollback flushes everything, including this cycle's allocation.
        alloc   = bus.issue_valid_in && issue_ready && !rollback;
        head_d  = retire ? head_q + IdxOne : head_q;
        tail_d  = alloc ? tail_q + IdxOne : tail_q;
        count_d = count_q;
        if (alloc && !retire)      count_d = count_q + CntOne;
        else if (!alloc && retire) count_d = count_q - CntOne;
        if (rollback) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= StRun;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            valid_q        <= '0;
            done_q         <= '0;
            mispred_q      <= '0;
            commit_valid_q <= 1'b0;
            store_commit_q <= 1'b0;
            rollback_q     <= 1'b0;
            commit_tag_q   <= IDX_W'(ROB_TAG_NULL);
            commit_rd_q    <= '0;
            commit_type_q  <= '0;
            commit_data_q  <= '0;
            commit_pc_q    <= '0;
            rollback_pc_q  <= '0;
        end else if (rdy_in) begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= head_fire;
            store_commit_q <= head_fire && head_store && !head_mis;
            rollback_q     <= rollback;
            if (head_fire) begin
                commit_tag_q  <= head_q;
                commit_rd_q   <= rd_q[head_q];
                commit_type_q <= type_q[head_q];
                commit_data_q <= data_q[head_q];
                commit_pc_q   <= pc_q[head_q];
            end
            if (rollback) begin
                rollback_pc_q <= npc_q[head_q];
                valid_q       <= '0;
                done_q        <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wb_hit[i] && valid_q[i]) begin
                        done_q[i]    <= 1'b1;
                        mispred_q[i] <= bus.wb_mispred_in[wb_sel[i]];
                    end
                end
                if (retire) valid_q[head_q] <= 1'b0;
                if (alloc) begin
                    valid_q[tail_q] <= 1'b1;
                    done_q[tail_q]  <= 1'b0;
                end
            end
        end
    end

    // Payload storage needs no reset: valid/done gate every read.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !rollback) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_hit[i] && valid_q[i]) begin
                    data_q[i] <= bus.wb_data_in[wb_sel[i]*XLEN +: XLEN];
                    npc_q[i]  <= bus.wb_npc_in[wb_sel[i]*XLEN +: XLEN];
                end
            end
            if (alloc) begin
                pc_q[tail_q]   <= bus.issue_pc_in;
                rd_q[tail_q]   <= bus.issue_rd_in;
                type_q[tail_q] <= bus.issue_type_in;
            end
        end
    end

`ifdef ROB_WB_BYPASS_EN
    logic            qa_hit, qb_hit;
    logic [SelW-1:0] qa_sel, qb_sel;

    rob_wb_match #(.IDX_W(IDX_W), .CDB_N(CDB_N), .SelW(SelW)) u_qa_match (
        .tag      (bus.qa_tag_in),
        .wb_valid (bus.wb_valid_in),
        .wb_tag   (bus.wb_tag_in),
        .hit      (qa_hit),
        .sel      (qa_sel)
    );
    rob_wb_match #(.IDX_W(IDX_W), .CDB_N(CDB_N), .SelW(SelW)) u_qb_match (
        .tag      (bus.qb_tag_in),
        .wb_valid (bus.wb_valid_in),
        .wb_tag   (bus.wb_tag_in),
        .hit      (qb_hit),
        .sel      (qb_sel)
    );
`endif

    always_comb begin
        bus.qa_ready_out = valid_q[bus.qa_tag_in] && done_q[bus.qa_tag_in];
        bus.qb_ready_out = valid_q[bus.qb_tag_in] && done_q[bus.qb_tag_in];
        bus.qa_data_out  = bus.qa_ready_out ? data_q[bus.qa_tag_in] : '0;
        bus.qb_data_out  = bus.qb_ready_out ? data_q[bus.qb_tag_in] : '0;
`ifdef ROB_WB_BYPASS_EN
        if (qa_hit && valid_q[bus.qa_tag_in]) begin
            bus.qa_ready_out = 1'b1;
            bus.qa_data_out  = bus.wb_data_in[qa_sel*XLEN +: XLEN];
        end
        if (qb_hit && valid_q[bus.qb_tag_in]) begin
            bus.qb_ready_out = 1'b1;
            bus.qb_data_out  = bus.wb_data_in[qb_sel*XLEN +: XLEN];
        end
`endif
    end

    assign bus.issue_ready_out  = issue_ready;
    assign bus.issue_tag_out    = tail_q;
    assign bus.count_out        = count_q;
    assign bus.commit_valid_out = commit_valid_q;
    assign bus.commit_tag_out   = commit_tag_q;
    assign bus.commit_rd_out    = commit_rd_q;
    assign bus.commit_type_out  = commit_type_q;
    assign bus.commit_data_out  = commit_data_q;
    assign bus.commit_pc_out    = commit_pc_q;
    assign bus.store_commit_out = store_commit_q;
    assign bus.rollback_out     = rollback_q;
    assign bus.rollback_pc_out  = rollback_pc_q;
endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc: ordering, full/wrap, store handshake, rollback,
// channel priority, query bypass, async reset and pause.
module tb_reorder_buffer_mc;
    import rob_pkg::*;

    logic clk;
    logic rst_n;
    logic rdy;
    int   checks = 0;
    int   errors = 0;

    reorder_buffer_mc_if #(.IDX_W(5), .CDB_N(3), .XLEN(32)) bus ();

    reorder_buffer_mc #(.DEPTH(32), .IDX_W(5), .CDB_N(3), .XLEN(32)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.issue_valid_in = 1'b0;
        bus.issue_pc_in    = '0;
        bus.issue_rd_in    = '0;
        bus.issue_type_in  = '0;
        bus.wb_valid_in    = '0;
        bus.wb_tag_in      = '0;
        bus.wb_data_in     = '0;
        bus.wb_npc_in      = '0;
        bus.wb_mispred_in  = '0;
        bus.qa_tag_in      = '0;
        bus.qb_tag_in      = '0;
        bus.store_done_in  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic [2:0] ty);
        bus.issue_valid_in = 1'b1;
        bus.issue_pc_in    = pc;
        bus.issue_rd_in    = rd;
        bus.issue_type_in  = ty;
        tick();
        bus.issue_valid_in = 1'b0;
    endtask

    task automatic wb_set(input int ch, input logic [4:0] tag, input logic [31:0] data,
                          input logic [31:0] npc, input logic mis);
        bus.wb_valid_in[ch]           = 1'b1;
        bus.wb_tag_in[ch*5 +: 5]      = tag;
        bus.wb_data_in[ch*32 +: 32]   = data;
        bus.wb_npc_in[ch*32 +: 32]    = npc;
        bus.wb_mispred_in[ch]         = mis;
    endtask

    task automatic wb_clr();
        bus.wb_valid_in   = '0;
        bus.wb_mispred_in = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b1;
        clear_inputs();
        #12;
        chk("rst_count", 64'(bus.count_out), 64'd0);
        chk("rst_ready", 64'(bus.issue_ready_out), 64'd1);
        chk("rst_commit", 64'(bus.commit_valid_out), 64'd0);
        chk("rst_tag", 64'(bus.issue_tag_out), 64'd0);
        chk("rst_rollback", 64'(bus.rollback_out), 64'd0);
        rst_n = 1'b1;
        tick();

        // In-order retirement with out-of-order writeback
        issue(32'h100, 5'd1, ROB_T_ALU);
        issue(32'h104, 5'd2, ROB_T_ALU);
        issue(32'h108, 5'd3, ROB_T_ALU);
        chk("t1_count3", 64'(bus.count_out), 64'd3);
        chk("t1_tail", 64'(bus.issue_tag_out), 64'd3);
        wb_set(0, 5'd1, 32'h11, 32'h0, 1'b0);
        tick();
        wb_clr();
        chk("t1_no_early", 64'(bus.commit_valid_out), 64'd0);
        wb_set(0, 5'd0, 32'h10, 32'h0, 1'b0);
        tick();
        wb_clr();
        chk("t1_latency", 64'(bus.commit_valid_out), 64'd0);
        tick();
        chk("t1_c0_valid", 64'(bus.commit_valid_out), 64'd1);
        chk("t1_c0_tag", 64'(bus.commit_tag_out), 64'd0);
        chk("t1_c0_data", 64'(bus.commit_data_out), 64'h10);
        chk("t1_c0_pc", 64'(bus.commit_pc_out), 64'h100);
        chk("t1_c0_rd", 64'(bus.commit_rd_out), 64'd1);
        tick();
        chk("t1_c1_valid", 64'(bus.commit_valid_out), 64'd1);
        chk("t1_c1_tag", 64'(bus.commit_tag_out), 64'd1);
        chk("t1_c1_data", 64'(bus.commit_data_out), 64'h11);
        tick();
        chk("t1_idle", 64'(bus.commit_valid_out), 64'd0);
        chk("t1_count1", 64'(bus.count_out), 64'd1);
        bus.qa_tag_in = 5'd1;
        bus.qb_tag_in = 5'd2;
        #1;
        chk("t1_qa_retired_rdy", 64'(bus.qa_ready_out), 64'd0);
        chk("t1_qa_retired_data", 64'(bus.qa_data_out), 64'd0);
        chk("t1_qb_pending", 64'(bus.qb_ready_out), 64'd0);

        // Full buffer, ignored overflow, no bypass of freed slot, tag wrap
        do_reset();
        for (int i = 0; i < 32; i++) issue(32'(i * 4), 5'd1, ROB_T_ALU);
        chk("t2_full_count", 64'(bus.count_out), 64'd32);
        chk("t2_full_ready", 64'(bus.issue_ready_out), 64'd0);
        issue(32'h999, 5'd1, ROB_T_ALU);
        chk("t2_overflow", 64'(bus.count_out), 64'd32);
        wb_set(0, 5'd0, 32'h77, 32'h0, 1'b0);
        tick();
        wb_clr();
        bus.issue_valid_in = 1'b1;
        bus.issue_pc_in    = 32'hABC;
        tick();
        chk("t2_retire_valid", 64'(bus.commit_valid_out), 64'd1);
        chk("t2_retire_tag", 64'(bus.commit_tag_out), 64'd0);
        chk("t2_no_bypass", 64'(bus.count_out), 64'd31);
        chk("t2_ready_again", 64'(bus.issue_ready_out), 64'd1);
        chk("t2_wrap_tag", 64'(bus.issue_tag_out), 64'd0);
        tick();
        bus.issue_valid_in = 1'b0;
        chk("t2_refill", 64'(bus.count_out), 64'd32);
        chk("t2_tail_after", 64'(bus.issue_tag_out), 64'd1);

        // Store handshake
        do_reset();
        issue(32'h300, 5'd0, ROB_T_ST);
        issue(32'h304, 5'd5, ROB_T_ALU);
        wb_set(0, 5'd0, 32'h55, 32'h0, 1'b0);
        wb_set(1, 5'd1, 32'h66, 32'h0, 1'b0);
        tick();
        wb_clr();
        bus.store_done_in = 1'b1;
        tick();
        bus.store_done_in = 1'b0;
        chk("t3_st_pulse", 64'(bus.store_commit_out), 64'd1);
        chk("t3_st_commit", 64'(bus.commit_valid_out), 64'd1);
        chk("t3_st_type", 64'(bus.commit_type_out), 64'(ROB_T_ST));
        chk("t3_done_in_run", 64'(bus.count_out), 64'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t3_wait_pulse", 64'(bus.store_commit_out), 64'd0);
            chk("t3_wait_commit", 64'(bus.commit_valid_out), 64'd0);
            chk("t3_wait_count", 64'(bus.count_out), 64'd2);
        end
        bus.store_done_in = 1'b1;
        tick();
        bus.store_done_in = 1'b0;
        chk("t3_done_count", 64'(bus.count_out), 64'd1);
        chk("t3_done_nocommit", 64'(bus.commit_valid_out), 64'd0);
        tick();
        chk("t3_next_valid", 64'(bus.commit_valid_out), 64'd1);
        chk("t3_next_tag", 64'(bus.commit_tag_out), 64'd1);
        chk("t3_next_data", 64'(bus.commit_data_out), 64'h66);
        chk("t3_next_nost", 64'(bus.store_commit_out), 64'd0);

        // Mispredict rollback with a concurrent issue
        do_reset();
        issue(32'h0, 5'd1, ROB_T_ALU);
        issue(32'h4, 5'd2, ROB_T_ALU);
        issue(32'h8, 5'd3, ROB_T_ALU);
        issue(32'hC, 5'd0, ROB_T_BR);
        wb_set(0, 5'd0, 32'h1, 32'h0, 1'b0);
        wb_set(1, 5'd1, 32'h2, 32'h0, 1'b0);
        wb_set(2, 5'd2, 32'h3, 32'h0, 1'b0);
        tick();
        wb_clr();
        wb_set(0, 5'd3, 32'h0, 32'h200, 1'b1);
        tick();
        wb_clr();
        chk("t4_c0", 64'(bus.commit_tag_out), 64'd0);
        tick();
        chk("t4_c1", 64'(bus.commit_tag_out), 64'd1);
        tick();
        chk("t4_c2", 64'(bus.commit_tag_out), 64'd2);
        chk("t4_c2_norb", 64'(bus.rollback_out), 64'd0);
        bus.issue_valid_in = 1'b1;
        bus.issue_pc_in    = 32'h500;
        bus.issue_type_in  = ROB_T_ALU;
        tick();
        bus.issue_valid_in = 1'b0;
        chk("t4_rb_pulse", 64'(bus.rollback_out), 64'd1);
        chk("t4_rb_pc", 64'(bus.rollback_pc_out), 64'h200);
        chk("t4_rb_tag", 64'(bus.commit_tag_out), 64'd3);
        chk("t4_rb_count", 64'(bus.count_out), 64'd0);
        chk("t4_rb_tail", 64'(bus.issue_tag_out), 64'd0);
        tick();
        chk("t4_rb_end", 64'(bus.rollback_out), 64'd0);
        chk("t4_rb_count2", 64'(bus.count_out), 64'd0);
        chk("t4_rb_idle", 64'(bus.commit_valid_out), 64'd0);
        bus.qa_tag_in = 5'd3;
        #1;
        chk("t4_q_flushed", 64'(bus.qa_ready_out), 64'd0);

        // Channel priority and query bypass
        do_reset();
        for (int i = 0; i < 5; i++) issue(32'(i * 4), 5'd1, ROB_T_ALU);
        wb_set(0, 5'd4, 32'hA, 32'h0, 1'b0);
        wb_set(2, 5'd4, 32'hC, 32'h0, 1'b0);
        bus.qa_tag_in = 5'd4;
        #1;
`ifdef ROB_WB_BYPASS_EN
        chk("t5_bypass_rdy", 64'(bus.qa_ready_out), 64'd1);
        chk("t5_bypass_data", 64'(bus.qa_data_out), 64'hC);
`else
        chk("t5_nobypass_rdy", 64'(bus.qa_ready_out), 64'd0);
        chk("t5_nobypass_data", 64'(bus.qa_data_out), 64'd0);
`endif
        tick();
        wb_clr();
        chk("t5_rdy", 64'(bus.qa_ready_out), 64'd1);
        chk("t5_prio_data", 64'(bus.qa_data_out), 64'hC);
        wb_set(1, 5'd10, 32'h99, 32'h0, 1'b0);
        tick();
        wb_clr();
        bus.qb_tag_in = 5'd10;
        #1;
        chk("t5_invalid_rdy", 64'(bus.qb_ready_out), 64'd0);
        chk("t5_invalid_data", 64'(bus.qb_data_out), 64'd0);
        chk("t5_count", 64'(bus.count_out), 64'd5);

        // Pause, then asynchronous reset while waiting on a store
        do_reset();
        issue(32'h400, 5'd0, ROB_T_ST);
        wb_set(0, 5'd0, 32'h1, 32'h0, 1'b0);
        tick();
        wb_clr();
        tick();
        chk("t6_st_pulse", 64'(bus.store_commit_out), 64'd1);
        rdy = 1'b0;
        bus.issue_valid_in = 1'b1;
        bus.store_done_in  = 1'b1;
        repeat (4) tick();
        chk("t6_hold_pulse", 64'(bus.store_commit_out), 64'd1);
        chk("t6_hold_commit", 64'(bus.commit_valid_out), 64'd1);
        chk("t6_hold_count", 64'(bus.count_out), 64'd1);
        chk("t6_hold_tail", 64'(bus.issue_tag_out), 64'd1);
        bus.issue_valid_in = 1'b0;
        bus.store_done_in  = 1'b0;
        rdy = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_commit", 64'(bus.commit_valid_out), 64'd0);
        chk("t6_arst_pulse", 64'(bus.store_commit_out), 64'd0);
        chk("t6_arst_count", 64'(bus.count_out), 64'd0);
        chk("t6_arst_ready", 64'(bus.issue_ready_out), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer_mc.md
Name: reorder_buffer_mc

Overview:
- Parametrised successor to the single-port ROB: in-order retirement buffer with configurable depth and N writeback (CDB) channels.
- Adds explicit occupancy count (all DEPTH slots usable), operand query ports for issue, and commit-time mispredict rollback that the ROB generates itself.
- Store retirement handshake is kept.
- Sits between decoder/issue queue (allocate), RS/LSB/ALU (writeback), and register file/LSB/fetch (commit, rollback).

Parameters:
DEPTH, 32, entries; must be a power of 2, at least 4
IDX_W, 5, tag width, equal to log2(DEPTH)
CDB_N, 3, number of writeback channels
XLEN, 32, data/PC width

Ports:
clk_in  in  1  system clock
rst_n_in  in  1  asynchronous active-low reset
rdy_in  in  1  global pause; all state frozen when low
issue_valid_in  in  1  allocate one entry this cycle
issue_pc_in  in  XLEN  instruction PC
issue_rd_in  in  5  destination register, 0 = none
issue_type_in  in  3  op type (ROB_T_* in package)
issue_ready_out  out  1  high when count < DEPTH; combinational from registered count
issue_tag_out  out  IDX_W  tag assigned to the current allocation (= tail)
wb_valid_in  in  CDB_N  per-channel writeback strobe
wb_tag_in  in  CDB_N*IDX_W  packed tags, channel 0 in the LSBs
wb_data_in  in  CDB_N*XLEN  packed results
wb_npc_in  in  CDB_N*XLEN  packed resolved next-PC
wb_mispred_in  in  CDB_N  resolved branch was mispredicted
qa_tag_in, qb_tag_in  in  IDX_W  operand query tags
qa_ready_out, qb_ready_out  out  1  queried entry is done
qa_data_out, qb_data_out  out  XLEN  queried entry result
commit_valid_out  out  1  one-cycle retire pulse
commit_tag_out  out  IDX_W  retired tag
commit_rd_out  out  5  retired destination register
commit_type_out  out  3  retired op type
commit_data_out  out  XLEN  retired result
commit_pc_out  out  XLEN  retired PC
store_commit_out  out  1  pulse: head store may write memory
store_done_in  in  1  memory controller finished the store
rollback_out  out  1  pulse: flush the pipeline
rollback_pc_out  out  XLEN  redirect target
count_out  out  IDX_W+1  occupancy

Behaviour:
- Reset (asynchronous, rst_n_in low): head=tail=0, count=0, all valid/done bits 0, FSM=RUN. All registered outputs 0. issue_ready_out=1.
- rdy_in low: no state change. Pulse outputs keep their last value; they are registered and updated only when rdy_in is high.
- Allocate: on issue_valid_in && issue_ready_out, write pc/rd/type to entry[tail] with done=0 and valid=1, then tail++ (wraps mod DEPTH). issue_valid_in while full is ignored.
- Writeback: each channel with a set strobe whose tag hits a valid entry sets done, data, npc and mispred. A tag that hits an invalid entry is ignored. Two channels carrying the same tag is illegal; the higher channel index wins.
- Latency: writeback sampled at edge E; the earliest commit pulse appears after edge E+1.
- FSM RUN, head valid and done:
  - Register the commit_* fields from head; commit_valid_out=1.
  - Non-store: head++, count--.
  - Store: store_commit_out=1, go to ST_WAIT, head not advanced.
  - Mispred set: also rollback_out=1 and rollback_pc_out=npc. On the same edge all valid bits clear, head=tail=0, count=0, and any same-cycle issue or writeback is dropped.
- FSM RUN otherwise: commit_valid_out=0, store_commit_out=0, rollback_out=0.
- ST_WAIT: no commits. On store_done_in: head++, count--, return to RUN. store_done_in while in RUN is ignored.
- Simultaneous allocate and retire: count is unchanged. A full ROB accepts no allocation in the same cycle as a retire (no bypass of the freed slot).
- Queries are combinational from stored state. An invalid tag returns ready=0, data=0.

Optional Feature:
- ROB_WB_BYPASS_EN defined: the query ports also match the current-cycle wb channels (highest channel index wins), so ready and data are visible the same cycle as the writeback.
- Not defined: a query sees a writeback one cycle later.

Decomposition:
- Package rob_pkg: ROB_T_* type encodings (ALU, BR, LD, ST, JAL), FSM state encodings, tag-null constant.
- One sub-module, rob_wb_match: per-entry CDB tag comparator plus priority select. It is reused by the query bypass.

Test Plan:
- Reset, then issue 3 ALU ops (tags 0,1,2); write back tag1=0x11 then tag0=0x10 -> commits in order tag0 (0x10) then tag1 (0x11); tag2 not retired; count_out=1.
- Fill 32 entries -> issue_ready_out=0 and a 33rd issue is ignored. Retire 1 -> ready=1; next allocation gets tag 0 after wrap.
- Store at head, done -> store_commit_out pulse; head holds for 5 cycles; store_done_in -> the next entry commits the following cycle.
- Branch tag3 written back with mispred=1, npc=0x200, issue asserted concurrently -> rollback_out pulse with pc 0x200, count_out=0, head=tail=0 next cycle.
- wb channels 0 and 2 write tags 4 and 4 with data 0xA and 0xC -> entry data 0xC. Query tag 4 in the writeback cycle -> ready=1 with ROB_WB_BYPASS_EN, ready=0 without.
- Pull rst_n_in low mid-ST_WAIT with no clock edge -> outputs clear immediately; hold rdy_in low 4 cycles -> no state change.
